// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Round-robin arbiter in front of a single shared binary-to-Gray converter.
//   Each cycle the output slot is free, one valid requester is granted, its
//   binary word is converted, and the result is registered into a one-entry
//   output stage with a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid                     [NREQ]
//   req_bin    requester i binary word at [i*WIDTH +: WIDTH]   [NREQ*WIDTH]
//   req_ready  one-hot grant, high only in the accepting cycle [NREQ]
//   out_valid  output register holds a converted word
//   out_ready  consumer accepts the output this cycle
//   out_gray   Gray code of the registered word                [WIDTH]
//   out_bin    original binary word                            [WIDTH]
//   out_id     index of the requester that produced the word   [IDW]
module gray_conv_arbiter #(
  parameter int unsigned  WIDTH = 4,
  parameter int unsigned  NREQ  = 4,
  localparam int unsigned IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [WIDTH-1:0] gray_q, bin_q;
  logic [IDW-1:0]   id_q;

  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] grant_bin;
  logic             grant_found;
  logic             slot_free;
  logic             accept;

  // Position reached by stepping k places past the last grant, wrapping at NREQ.
  // last < NREQ and k <= NREQ, so a single subtraction is enough.
  function automatic int unsigned rr_pos(logic [IDW-1:0] last, int unsigned k);
    int unsigned p;
    p = 32'(last) + k;
    if (p >= NREQ) p = p - NREQ;
    return p;
  endfunction

  // Round-robin search: offsets 1..NREQ past the last grant, first valid wins.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_bin   = '0;
    grant_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && (i == rr_pos(last_grant_q, k))) begin
          grant_found = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = IDW'(i);
          grant_bin   = WIDTH'(req_bin >> (i * WIDTH));
        end
      end
    end
  end

  // Slot frees up either when empty or when the held word drains this cycle.
  assign slot_free = (state_q == StEmpty) || out_ready;
  assign accept    = slot_free && (|req_valid);
  assign req_ready = accept ? grant_oh : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (accept)         state_d = StFull;
        else if (out_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      last_grant_q <= IDW'(NREQ - 1);
      gray_q       <= '0;
      bin_q        <= '0;
      id_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gray_q       <= grant_bin ^ (grant_bin >> 1);
        bin_q        <= grant_bin;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_gray  = gray_q;
  assign out_bin   = bin_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed stimulus, a transaction-level model of
// the output slot and round-robin pointer, and literal expectations.
`timescale 1ns/1ps
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_bin;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_gray;
  logic [3:0]  out_bin;
  logic [1:0]  out_id;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: one output slot plus the last granted index.
  logic       m_valid;
  logic [3:0] m_gray;
  logic [3:0] m_bin;
  int         m_id;
  int         m_last;

  logic [3:0] seq_gray [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
  int         fair_order [5] = '{3, 1, 3, 1, 3};

  gray_conv_arbiter #(
    .WIDTH(WIDTH),
    .NREQ (NREQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_bin  (req_bin),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gray (out_gray),
    .out_bin  (out_bin),
    .out_id   (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] bin_to_gray(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] word_of(logic [15:0] bus, int j);
    return 4'(bus >> (4 * j));
  endfunction

  function automatic int rr_pick(logic [3:0] v, int last);
    for (int d = 1; d <= NREQ; d++) begin
      if (v[(last + d) % NREQ]) return (last + d) % NREQ;
    end
    return -1;
  endfunction

  // Index the model grants this cycle, or -1 when nothing is accepted.
  function automatic int exp_grant();
    if (m_valid && !out_ready) return -1;
    return rr_pick(req_valid, m_last);
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_gray  <= '0;
      m_bin   <= '0;
      m_id    <= 0;
      m_last  <= NREQ - 1;
    end else if (exp_grant() >= 0) begin
      m_valid <= 1'b1;
      m_gray  <= bin_to_gray(word_of(req_bin, exp_grant()));
      m_bin   <= word_of(req_bin, exp_grant());
      m_id    <= exp_grant();
      m_last  <= exp_grant();
    end else if (!m_valid || out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, exp_ready());
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_gray", out_gray, m_gray);
      check("out_bin", out_bin, m_bin);
      check("out_id", out_id, m_id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_gray", out_gray, 0);
    check("rst_out_id", out_id, 0);

    // First grant after reset goes to requester 0
    step();
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_bin   = 16'h000B;
    out_ready = 1'b1;
    @(negedge clk);
    check("first_ready", req_ready, 4'b0001);
    step();
    check("first_valid", out_valid, 1);
    check("first_gray", out_gray, 4'b1110);
    check("first_id", out_id, 0);

    // Park pointer on 3, then all four valid -> grants 0,1,2,3
    req_bin   = 16'h3210;
    req_valid = 4'b1000;
    step();
    check("pre_id3", out_id, 3);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_ready", req_ready, 4'b0001 << i);
      step();
      check("seq_gray", out_gray, seq_gray[i]);
      check("seq_id", out_id, i);
    end

    // Drain, then load a word and stall it
    req_valid = 4'b0000;
    step();
    check("drain_valid", out_valid, 0);
    req_bin   = 16'h0050;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    step();
    check("bp_load_gray", out_gray, 4'b0111);
    check("bp_load_id", out_id, 1);
    req_valid = 4'b0100;
    req_bin   = 16'h0950;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", req_ready, 4'b0000);
      check("bp_valid", out_valid, 1);
      check("bp_gray", out_gray, 4'b0111);
      check("bp_id", out_id, 1);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("reload_ready", req_ready, 4'b0100);
    step();
    check("reload_valid", out_valid, 1);
    check("reload_gray", out_gray, 4'b1101);
    check("reload_id", out_id, 2);

    // Fairness between requesters 1 and 3, then requester 0 joins
    req_bin   = 16'hC962;
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("fair_ready", req_ready, 4'b0001 << fair_order[k]);
      step();
      check("fair_id", out_id, fair_order[k]);
    end
    req_valid = 4'b1011;
    @(negedge clk);
    check("join_ready", req_ready, 4'b0001);
    step();
    check("join_id", out_id, 0);
    check("join_gray", out_gray, 4'b0011);

    // Every 4-bit word through requester 2
    req_valid = 4'b0100;
    for (int b = 0; b < 16; b++) begin
      req_bin = 16'(b) << 8;
      step();
      check("ex_gray", out_gray, bin_to_gray(4'(b)));
      check("ex_bin", out_bin, b);
      if (b == 8)  check("ex_gray8", out_gray, 4'b1100);
      if (b == 15) check("ex_gray15", out_gray, 4'b1000);
    end
    out_ready = 1'b0;
    req_valid = 4'b0000;

    // Asynchronous reset between edges while a word is held
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_gray", out_gray, 0);
    check("mid_rst_id", out_id, 0);
    step();
    rst_n     = 1'b1;
    req_bin   = 16'h7531;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 4'b0001);
    step();
    check("post_rst_id", out_id, 0);
    check("post_rst_gray", out_gray, 4'b0001);

    req_valid = 4'b0000;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
